// File: rtl/cfg_readback.sv
// Configuration readback responder: shadows every bus write and streams a stored word back as beats.
// Optional macro CFG_RDBK_HDR_EN prefixes each response with an {addr[7:0], chan[7:0]} header beat.
module cfg_readback #(
    parameter int N_CHAN    = 5,
    parameter int N_ADDR    = 16,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48,
    parameter int W_BEAT    = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 wr_en,
    input  logic [W_WR_ADDR-1:0] wr_addr,
    input  logic [W_WR_CHAN-1:0] wr_chan,
    input  logic [W_WR_DATA-1:0] wr_data,
    input  logic                 rd_req,
    input  logic [W_WR_ADDR-1:0] rd_addr,
    input  logic [W_WR_CHAN-1:0] rd_chan,
    output logic                 rd_busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W_BEAT-1:0]    rsp_data,
    output logic                 rsp_last,
    output logic                 rsp_err
);

    localparam int N_BEAT = W_WR_DATA / W_BEAT;
    localparam int AW     = (N_ADDR > 1) ? $clog2(N_ADDR) : 1;
    localparam int CW     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int CNT_W  = $clog2(N_BEAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t                 state_r;
    logic [W_WR_ADDR-1:0]   req_addr_r;
    logic [W_WR_CHAN-1:0]   req_chan_r;
    logic [W_WR_DATA-1:0]   shift_r;
    logic [CNT_W-1:0]       remain_r;
    logic [W_WR_DATA-1:0]   store_r [N_ADDR][N_CHAN];

    logic                   wr_hit_s;
    logic                   req_ok_s;
    logic                   collide_s;
    logic [W_WR_DATA-1:0]   entry_s;
`ifdef CFG_RDBK_HDR_EN
    logic [15:0]            hdr16_s;
    logic [W_BEAT-1:0]      hdr_s;
`endif

    // Range checks and write-first lookup of the latched request
    always_comb begin
        wr_hit_s  = wr_en && (wr_addr < W_WR_ADDR'(N_ADDR)) && (wr_chan < W_WR_CHAN'(N_CHAN));
        req_ok_s  = (req_addr_r < W_WR_ADDR'(N_ADDR)) && (req_chan_r < W_WR_CHAN'(N_CHAN));
        collide_s = wr_hit_s && (wr_addr == req_addr_r) && (wr_chan == req_chan_r);
        entry_s   = '0;
        if (collide_s) begin
            entry_s = wr_data;
        end else if (req_ok_s) begin
            entry_s = store_r[req_addr_r[AW-1:0]][req_chan_r[CW-1:0]];
        end else begin
            entry_s = '0;
        end
    end

`ifdef CFG_RDBK_HDR_EN
    // Header beat built from the low bytes of the latched address and channel
    always_comb begin
        hdr16_s = {req_addr_r[7:0], req_chan_r[7:0]};
        hdr_s   = W_BEAT'(hdr16_s);
    end
`endif

    // Shadow store: in-range writes land at the clock edge, everything clears on reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int a = 0; a < N_ADDR; a++) begin
                for (int c = 0; c < N_CHAN; c++) begin
                    store_r[a][c] <= '0;
                end
            end
        end else if (wr_hit_s) begin
            store_r[wr_addr[AW-1:0]][wr_chan[CW-1:0]] <= wr_data;
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            req_addr_r <= '0;
            req_chan_r <= '0;
            shift_r    <= '0;
            remain_r   <= '0;
            rd_busy    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_req) begin
                        req_addr_r <= rd_addr;
                        req_chan_r <= rd_chan;
                        rd_busy    <= 1'b1;
                        state_r    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_r   <= ST_SEND;
                    rsp_valid <= 1'b1;
                    rsp_err   <= !req_ok_s;
`ifdef CFG_RDBK_HDR_EN
                    // Error responses carry the header plus one zero beat
                    rsp_data  <= hdr_s;
                    rsp_last  <= 1'b0;
                    shift_r   <= entry_s;
                    remain_r  <= req_ok_s ? CNT_W'(N_BEAT) : CNT_W'(1);
`else
                    rsp_data  <= entry_s[W_WR_DATA-1 -: W_BEAT];
                    shift_r   <= entry_s << W_BEAT;
                    if (req_ok_s) begin
                        remain_r <= CNT_W'(N_BEAT - 1);
                        rsp_last <= (N_BEAT == 1);
                    end else begin
                        remain_r <= '0;
                        rsp_last <= 1'b1;
                    end
`endif
                end
                ST_SEND: begin
                    if (rsp_valid && rsp_ready) begin
                        if (rsp_last) begin
                            state_r   <= ST_IDLE;
                            rd_busy   <= 1'b0;
                            rsp_valid <= 1'b0;
                            rsp_data  <= '0;
                            rsp_last  <= 1'b0;
                            rsp_err   <= 1'b0;
                        end else begin
                            rsp_data <= shift_r[W_WR_DATA-1 -: W_BEAT];
                            shift_r  <= shift_r << W_BEAT;
                            remain_r <= remain_r - CNT_W'(1);
                            rsp_last <= (remain_r == CNT_W'(1));
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rd_busy   <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_data  <= '0;
                    rsp_last  <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_readback.sv
// Self-checking bench for cfg_readback: directed scenarios plus random traffic against an array model.
module tb_cfg_readback;

    localparam int N_CHAN = 5;
    localparam int N_ADDR = 16;
    localparam int W_B    = 16;
    localparam int N_BEAT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = 16'h0;
    logic [15:0] wr_chan = 16'h0;
    logic [47:0] wr_data = 48'h0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    logic [15:0] rd_chan = 16'h0;
    logic        rd_busy;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;
    logic [47:0] mdl [N_ADDR][N_CHAN];
    logic [15:0] exp_q [$];
    logic        exp_err;

    always #5 clk_in = ~clk_in;

    cfg_readback dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_busy(rd_busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int a = 0; a < N_ADDR; a++)
            for (int c = 0; c < N_CHAN; c++)
                mdl[a][c] = 48'h0;
    endtask

    task automatic mdl_write(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        if (a < N_ADDR && c < N_CHAN) mdl[a][c] = d;
    endtask

    // Expected beat list for a read of (a,c) given the current model contents
    task automatic build_exp(input logic [15:0] a, input logic [15:0] c);
        exp_q.delete();
        exp_err = !(a < N_ADDR && c < N_CHAN);
`ifdef CFG_RDBK_HDR_EN
        exp_q.push_back({a[7:0], c[7:0]});
`endif
        if (exp_err) exp_q.push_back(16'h0);
        else
            for (int i = 0; i < N_BEAT; i++)
                exp_q.push_back(16'(mdl[a][c] >> (W_B * (N_BEAT - 1 - i))));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = d;
        @(negedge clk_in);
        wr_en = 1'b0;
        mdl_write(a, c, d);
    endtask

    // rdy_mode: 0 = always ready, 1 = random, 2 = stall five cycles after beat 0
    task automatic do_read(input logic [15:0] a, input logic [15:0] c, input int rdy_mode,
                           input logic col_wr, input logic [47:0] col_data,
                           input logic stall_wr, input logic [47:0] stall_data,
                           input logic busy_req);
        int  cyc;
        logic rdy;
        rd_req = 1'b1; rd_addr = a; rd_chan = c;
        @(negedge clk_in);
        rd_req = 1'b0;
        chk("busy_lookup", rd_busy, 1);
        chk("valid_lookup", rsp_valid, 0);
        if (col_wr) begin
            wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = col_data;
            mdl_write(a, c, col_data);
        end
        build_exp(a, c);
        @(negedge clk_in);
        wr_en = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 100) begin
                vectors++; miscompares++;
                $error("FAIL timeout: observed %0d cycles, expected at most 100", cyc);
                break;
            end
            chk("valid", rsp_valid, 1);
            chk("data", rsp_data, exp_q[0]);
            chk("last", rsp_last, exp_q.size() == 1);
            chk("err", rsp_err, exp_err);
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 5);
            endcase
            if (stall_wr && cyc == 1) begin
                wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = stall_data;
                mdl_write(a, c, stall_data);
            end
            if (busy_req && cyc == 1) begin
                rd_req = 1'b1; rd_addr = a ^ 16'h1; rd_chan = c;
            end
            rsp_ready = rdy;
            @(negedge clk_in);
            wr_en = 1'b0;
            rd_req = 1'b0;
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        rsp_ready = 1'b0;
        chk("busy_done", rd_busy, 0);
        chk("valid_done", rsp_valid, 0);
        if (busy_req) begin
            @(negedge clk_in);
            chk("ignored_req_busy", rd_busy, 0);
            chk("ignored_req_valid", rsp_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        mdl_clear();
        repeat (2) @(negedge clk_in);
        chk("rst_busy", rd_busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_last", rsp_last, 0);
        chk("rst_err", rsp_err, 0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Basic write then full-rate readback
        do_write(16'd3, 16'd2, 48'h1234_5678_9ABC);
        do_read(16'd3, 16'd2, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);

        // Out-of-range address and channel
        do_read(16'd20, 16'd0, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);
        do_read(16'd0, 16'd7, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);
        do_write(16'd16, 16'd0, 48'hDEAD_BEEF_0001);
        do_write(16'd0, 16'd5, 48'hDEAD_BEEF_0002);
        do_read(16'd0, 16'd0, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);

        // Stall with a write to the same entry mid-response, then read the new value
        do_write(16'd1, 16'd1, 48'h1111_2222_3333);
        do_read(16'd1, 16'd1, 2, 1'b0, 48'h0, 1'b1, 48'h4444_5555_6666, 1'b0);
        do_read(16'd1, 16'd1, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);

        // Write-first collision in the lookup cycle, plus a request while busy
        do_write(16'd4, 16'd0, 48'h0102_0304_0506);
        do_read(16'd4, 16'd0, 0, 1'b1, 48'hAAAA_BBBB_CCCC, 1'b0, 48'h0, 1'b1);

        // Reset asserted while beat 1 is presented
        rd_req = 1'b1; rd_addr = 16'd3; rd_chan = 16'd2;
        build_exp(16'd3, 16'd2);
        @(negedge clk_in);
        rd_req = 1'b0;
        @(negedge clk_in);
        chk("rstmid_beat0", rsp_data, exp_q[0]);
        rsp_ready = 1'b1;
        @(negedge clk_in);
        chk("rstmid_beat1", rsp_data, exp_q[1]);
        rsp_ready = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk("rstmid_valid", rsp_valid, 0);
        chk("rstmid_busy", rd_busy, 0);
        chk("rstmid_data", rsp_data, 0);
        chk("rstmid_last", rsp_last, 0);
        chk("rstmid_err", rsp_err, 0);
        mdl_clear();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("postrst_valid", rsp_valid, 0);
        do_read(16'd3, 16'd2, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);
        do_read(16'd4, 16'd0, 0, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);

        // Random writes and reads with random back-pressure
        for (int n = 0; n < 60; n++) begin
            rnd = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0)
                do_write(16'($urandom_range(0, 19)), 16'($urandom_range(0, 6)), rnd[47:0]);
            else
                do_read(16'($urandom_range(0, 18)), 16'($urandom_range(0, 5)), 1,
                        1'b0, 48'h0, 1'b0, 48'h0, 1'b0);
        end
        for (int a = 0; a < N_ADDR; a += 5)
            for (int c = 0; c < N_CHAN; c++)
                do_read(16'(a), 16'(c), 1, 1'b0, 48'h0, 1'b0, 48'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
